// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, decode and the register-file
// write-port arbiter.
//   alu_*      : ALU result source (valid/rd/data in, ready back)
//   mem_*      : load result source (valid/rd/data in, ready back)
//   issue_*    : decode notifies an issued instruction that writes issue_rd
//   rf_*       : registered register-file write port
//   pending    : per-register outstanding-write scoreboard
//   byp_*      : optional same-cycle read bypass (RF_WB_BYPASS_EN)
// Modports: master = sources/decode/register-file side, slave = the arbiter.
interface regfile_wb_arbiter_if;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    logic                alu_valid;
    logic [REG_AW-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;

    logic                mem_valid;
    logic [REG_AW-1:0]   mem_rd;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;

    logic                issue_valid;
    logic [REG_AW-1:0]   issue_rd;

    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [NUM_REGS-1:0] pending;

`ifdef RF_WB_BYPASS_EN
    logic [REG_AW-1:0]   byp_rs1;
    logic [REG_AW-1:0]   byp_rs2;
    logic                byp_hit1;
    logic                byp_hit2;
    logic [DATA_W-1:0]   byp_data1;
    logic [DATA_W-1:0]   byp_data2;

    modport master (
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output mem_valid, mem_rd, mem_data, input mem_ready,
        output issue_valid, issue_rd,
        input  rf_we, rf_waddr, rf_wdata, pending,
        output byp_rs1, byp_rs2,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, output alu_ready,
        input  mem_valid, mem_rd, mem_data, output mem_ready,
        input  issue_valid, issue_rd,
        output rf_we, rf_waddr, rf_wdata, pending,
        input  byp_rs1, byp_rs2,
        output byp_hit1, byp_hit2, byp_data1, byp_data2
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output mem_valid, mem_rd, mem_data, input mem_ready,
        output issue_valid, issue_rd,
        input  rf_we, rf_waddr, rf_wdata, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, output alu_ready,
        input  mem_valid, mem_rd, mem_data, output mem_ready,
        input  issue_valid, issue_rd,
        output rf_we, rf_waddr, rf_wdata, pending
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port between the ALU and load
// writeback sources: load has fixed priority, but an ALU result refused for
// MAX_WAIT consecutive cycles wins the next arbitration. Accepted results pass
// through one registered write stage to the rf_* port. A 32-entry pending-write
// scoreboard (set at issue, cleared the cycle after the register-file write)
// lets decode stall on RAW/WAW hazards.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : regfile_wb_arbiter_if.slave (alu_*, mem_*, issue_*, rf_*, pending,
//            and byp_* when RF_WB_BYPASS_EN is defined)
// Parameter: MAX_WAIT (1..255) ALU refusal cycles before it is forced through.
// Optional feature macro: RF_WB_BYPASS_EN (combinational read bypass of the
// value currently on the write port).
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 8;

    logic [CNT_W-1:0]    wait_cnt;
    logic                alu_starved;
    logic                alu_grant;
    logic                mem_grant;
    logic                alu_xfer;
    logic                mem_xfer;
    logic                wb_fire;
    logic [REG_AW-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;

    logic                rf_we_q;
    logic [REG_AW-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_nxt;

    // Grant: load first unless the ALU has been refused MAX_WAIT cycles.
    always_comb begin
        alu_starved = (wait_cnt == CNT_W'(MAX_WAIT));
        mem_grant   = bus.mem_valid && !(bus.alu_valid && alu_starved);
        alu_grant   = bus.alu_valid && (!bus.mem_valid || alu_starved);
        alu_xfer    = alu_grant && rst_n;
        mem_xfer    = mem_grant && rst_n;
        wb_fire     = alu_xfer || mem_xfer;
        wb_rd       = alu_xfer ? bus.alu_rd   : bus.mem_rd;
        wb_data     = alu_xfer ? bus.alu_data : bus.mem_data;
    end

    assign bus.alu_ready = alu_xfer;
    assign bus.mem_ready = mem_xfer;

    // Starvation counter: counts refused ALU cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!bus.alu_valid || alu_xfer) begin
            wait_cnt <= '0;
        end else if (!alu_starved) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Write stage: one-cycle pulse per transfer; x0 writes are swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (wb_fire) begin
            if (wb_rd != '0) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= wb_rd;
                rf_wdata_q <= wb_data;
            end else begin
                rf_we_q    <= 1'b0;
                rf_waddr_q <= '0;
                rf_wdata_q <= '0;
            end
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    // Scoreboard next state: a new issue beats the retiring write on the same register.
    always_comb begin
        pending_nxt = pending_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (bus.issue_valid && (bus.issue_rd == REG_AW'(i))) begin
                pending_nxt[i] = 1'b1;
            end else if (rf_we_q && (rf_waddr_q == REG_AW'(i))) begin
                pending_nxt[i] = 1'b0;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.pending  = pending_q;

`ifdef RF_WB_BYPASS_EN
    // Same-cycle bypass of the value on the write port; x0 never hits.
    always_comb begin
        bus.byp_hit1  = rf_we_q && (rf_waddr_q == bus.byp_rs1) && (bus.byp_rs1 != '0);
        bus.byp_hit2  = rf_we_q && (rf_waddr_q == bus.byp_rs2) && (bus.byp_rs2 != '0);
        bus.byp_data1 = bus.byp_hit1 ? rf_wdata_q : '0;
        bus.byp_data2 = bus.byp_hit2 ? rf_wdata_q : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table plus hand sequences for
// reset, contention and (when RF_WB_BYPASS_EN is defined) bypass.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        mem_valid;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        issue_valid;
        logic [4:0]  issue_rd;
        logic        exp_alu_ready;
        logic        exp_mem_ready;
        logic        exp_we;
        logic        chk_wd;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_pending;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    initial begin
        //          av rd  adata         mv rd  mdata         iv ird  ar mr we cw waddr wdata         pending
        vec[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,   0, 0, 0, 0, 0,  32'h0,        32'h0};
        vec[1]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,   1, 0, 1, 1, 5,  32'hDEADBEEF, 32'h0};
        vec[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,   0, 0, 0, 0, 0,  32'h0,        32'h0};
        vec[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7,   0, 0, 0, 0, 0,  32'h0,        32'h80};
        vec[4]  = '{1, 7,  32'h77,       0, 0,  32'h0,        0, 0,   1, 0, 1, 1, 7,  32'h77,       32'h80};
        vec[5]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,   0, 0, 0, 0, 0,  32'h0,        32'h0};
        vec[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7,   0, 0, 0, 0, 0,  32'h0,        32'h80};
        vec[7]  = '{1, 7,  32'h11,       0, 0,  32'h0,        0, 0,   1, 0, 1, 1, 7,  32'h11,       32'h80};
        vec[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7,   0, 0, 0, 0, 0,  32'h0,        32'h80};
        vec[9]  = '{1, 7,  32'h22,       0, 0,  32'h0,        0, 0,   1, 0, 1, 1, 7,  32'h22,       32'h80};
        vec[10] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,   0, 0, 0, 0, 0,  32'h0,        32'h0};
        vec[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 0,   0, 0, 0, 0, 0,  32'h0,        32'h0};
        vec[12] = '{0, 0,  32'h0,        1, 0,  32'h1234,     0, 0,   0, 1, 0, 1, 0,  32'h0,        32'h0};
        vec[13] = '{0, 0,  32'h0,        1, 3,  32'hA5,       0, 0,   0, 1, 1, 1, 3,  32'hA5,       32'h0};
        vec[14] = '{1, 9,  32'h99,       0, 0,  32'h0,        1, 4,   1, 0, 1, 1, 9,  32'h99,       32'h10};
        vec[15] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,   0, 0, 0, 0, 0,  32'h0,        32'h10};

        drive_idle();
`ifdef RF_WB_BYPASS_EN
        bus.byp_rs1 = '0;
        bus.byp_rs2 = '0;
`endif
        // Reset state, with a valid ALU source that must not be granted.
        rst_n = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("rst_rf_we",     32'(bus.rf_we),     32'd0);
        check("rst_waddr",     32'(bus.rf_waddr),  32'd0);
        check("rst_wdata",     bus.rf_wdata,       32'd0);
        check("rst_pending",   bus.pending,        32'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // Table vectors: ready sampled before the edge, write port after it.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.alu_valid   = vec[i].alu_valid;
            bus.alu_rd      = vec[i].alu_rd;
            bus.alu_data    = vec[i].alu_data;
            bus.mem_valid   = vec[i].mem_valid;
            bus.mem_rd      = vec[i].mem_rd;
            bus.mem_data    = vec[i].mem_data;
            bus.issue_valid = vec[i].issue_valid;
            bus.issue_rd    = vec[i].issue_rd;
            #1;
            check($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vec[i].exp_alu_ready));
            check($sformatf("v%0d_mem_ready", i), 32'(bus.mem_ready), 32'(vec[i].exp_mem_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rf_we", i), 32'(bus.rf_we), 32'(vec[i].exp_we));
            if (vec[i].chk_wd) begin
                check($sformatf("v%0d_waddr", i), 32'(bus.rf_waddr), 32'(vec[i].exp_waddr));
                check($sformatf("v%0d_wdata", i), bus.rf_wdata, vec[i].exp_wdata);
            end
            check($sformatf("v%0d_pending", i), bus.pending, vec[i].exp_pending);
        end

        // Contention: ALU forced through every 4th cycle with MAX_WAIT=3.
        for (int k = 0; k < 8; k++) begin
            logic alu_win;
            alu_win = ((k % 4) == 3);
            @(negedge clk);
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'd1;
            bus.alu_data  = 32'hA0 + 32'(k / 4);
            bus.mem_valid = 1'b1;
            bus.mem_rd    = 5'd2;
            bus.mem_data  = 32'(k);
            #1;
            check($sformatf("cont%0d_alu_ready", k), 32'(bus.alu_ready), 32'(alu_win));
            check($sformatf("cont%0d_mem_ready", k), 32'(bus.mem_ready), 32'(!alu_win));
            @(posedge clk);
            #1;
            check($sformatf("cont%0d_rf_we", k), 32'(bus.rf_we), 32'd1);
            check($sformatf("cont%0d_waddr", k), 32'(bus.rf_waddr), alu_win ? 32'd1 : 32'd2);
            check($sformatf("cont%0d_wdata", k), bus.rf_wdata,
                  alu_win ? (32'hA0 + 32'(k / 4)) : 32'(k));
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("cont_idle_rf_we", 32'(bus.rf_we), 32'd0);

`ifdef RF_WB_BYPASS_EN
        // Bypass of the value being written this cycle.
        @(negedge clk);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'h55;
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b0;
        bus.byp_rs1   = 5'd9;
        bus.byp_rs2   = 5'd0;
        #1;
        check("byp_hit1",  32'(bus.byp_hit1), 32'd1);
        check("byp_data1", bus.byp_data1,     32'h55);
        check("byp_hit2",  32'(bus.byp_hit2), 32'd0);
        check("byp_data2", bus.byp_data2,     32'h0);
        @(posedge clk);
        #1;
        check("byp_hit1_after", 32'(bus.byp_hit1), 32'd0);
        bus.byp_rs1 = '0;
`endif

        // Reset mid-operation: write stage and scoreboard discarded at once.
        @(negedge clk);
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd6;
        bus.alu_data    = 32'h66;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        @(posedge clk);
        #1;
        check("mid_rf_we_pre",   32'(bus.rf_we), 32'd1);
        check("mid_pending_pre", bus.pending,    32'h1010);
        bus.issue_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rf_we",     32'(bus.rf_we),     32'd0);
        check("mid_rst_pending",   bus.pending,        32'd0);
        check("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rf_we",   32'(bus.rf_we), 32'd0);
        check("post_rst_pending", bus.pending,    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
